// File: rtl/asic_ctrlring_master_if.sv
// Core-side bundle for the padring control-ring master: config/sense handshake
// plus the raw ring drive, enable and receive lanes.
interface asic_ctrlring_master_if #(
    parameter int NCTRL = 8,
    parameter int CW    = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_data;
    logic             sense_valid;
    logic [CW-1:0]    sense_data;
    logic             busy;
    logic [NCTRL-1:0] ctrl_out;
    logic [NCTRL-1:0] ctrl_oe;
    logic [NCTRL-1:0] ctrl_in;

    modport master (
        input  cfg_valid, cfg_data, ctrl_in,
        output cfg_ready, sense_valid, sense_data, busy, ctrl_out, ctrl_oe
    );

    modport slave (
        output cfg_valid, cfg_data, ctrl_in,
        input  cfg_ready, sense_valid, sense_data, busy, ctrl_out, ctrl_oe
    );
endinterface

// File: rtl/asic_ctrlring_master.sv
// Shifts a config word MSB-first onto the padring control chain with a divided
// ring clock, captures the returned sense bits, strobes load and reports the sense word.
module asic_ctrlring_master #(
    parameter int NCTRL = 8,
    parameter int CW    = 32,
    parameter int DIV   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    asic_ctrlring_master_if.master bus
);
    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(CW + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cap_q, cap_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [DW-1:0]   divcnt_q, divcnt_d;
    logic            cfg_ready_q, busy_q, sclk_q, sdo_q, load_q, sense_valid_q;
    logic [CW-1:0]   sense_data_q;
    logic            div_last;
    logic [CW:0]     cap_shift;

    // Sense return is used raw; the ring side is already synchronized to clk.
    assign cap_shift = {cap_q, bus.ctrl_in[3]};

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cap_d    = cap_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        div_last = (divcnt_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && cfg_ready_q) begin
                    shreg_d  = bus.cfg_data;
                    bitcnt_d = BW'(CW);
                    divcnt_d = '0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    divcnt_d = '0;
                    state_d  = SHIFT_HI;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    divcnt_d = '0;
                    cap_d    = cap_shift[CW-1:0];
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - 1'b1;
                    state_d  = (bitcnt_q == BW'(1)) ? LOAD : SHIFT_LO;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (div_last) begin
                    divcnt_d = '0;
                    state_d  = DONE;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bitcnt_q      <= '0;
            divcnt_q      <= '0;
            cfg_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            sclk_q        <= 1'b0;
            sdo_q         <= 1'b0;
            load_q        <= 1'b0;
            sense_valid_q <= 1'b0;
            sense_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            divcnt_q      <= divcnt_d;
            cfg_ready_q   <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
            sclk_q        <= (state_d == SHIFT_HI);
            sdo_q         <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && shreg_d[CW-1];
            load_q        <= (state_d == LOAD);
            sense_valid_q <= (state_d == DONE);
            if (state_d == DONE) begin
                sense_data_q <= cap_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        cap_q   <= cap_d;
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.busy        = busy_q;
    assign bus.sense_valid = sense_valid_q;
    assign bus.sense_data  = sense_data_q;
    assign bus.ctrl_out    = {{(NCTRL-3){1'b0}}, load_q, sdo_q, sclk_q};
    assign bus.ctrl_oe     = {{(NCTRL-3){1'b0}}, 3'b111};

endmodule

// File: tb/tb_asic_ctrlring_master.sv
// Directed bench for asic_ctrlring_master: CW=8/DIV=2 instance for the main
// transfers and a CW=1/DIV=1 instance for the minimal configuration.
module tb_asic_ctrlring_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst1;
    int   mode;
    logic sdi;
    int   n_pass, n_total;

    asic_ctrlring_master_if #(.NCTRL(8), .CW(8)) if8 ();
    asic_ctrlring_master_if #(.NCTRL(4), .CW(1)) if1 ();

    asic_ctrlring_master #(.NCTRL(8), .CW(8), .DIV(2)) dut8 (.clk(clk), .reset(rst8), .bus(if8));
    asic_ctrlring_master #(.NCTRL(4), .CW(1), .DIV(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1));

    // Ring model: 0 loopback, 1 inverted loopback, 2 tied 0, 3 tied 1
    always_comb begin
        case (mode)
            0:       sdi = if8.ctrl_out[1];
            1:       sdi = ~if8.ctrl_out[1];
            2:       sdi = 1'b0;
            default: sdi = 1'b1;
        endcase
    end
    assign if8.ctrl_in = {4'b0000, sdi, 3'b000};
    assign if1.ctrl_in = 4'b1000;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic [7:0] exp_sense;
        string      name;
    } vec_t;
    vec_t vecs [6];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    task automatic accept(input logic [7:0] d, input string tag);
        @(negedge clk);
        check({tag, " ready_before"}, 32'(if8.cfg_ready), 1);
        if8.cfg_valid = 1'b1;
        if8.cfg_data  = d;
        @(posedge clk);
    endtask

    // Observes one transfer from the cycle after the accepting edge up to the sense_valid cycle.
    task automatic watch(input logic [7:0] exp_word, input logic [7:0] exp_sense,
                         input logic hold, input logic [7:0] next_data, input string tag);
        int n, lo, hi, pulses, loads;
        logic [7:0] word;
        logic prev, bad_lo, bad_hi, bad_rdy, seen;
        n = 0; lo = 0; hi = 0; pulses = 0; loads = 0; word = '0;
        prev = 1'b0; bad_lo = 1'b0; bad_hi = 1'b0; bad_rdy = 1'b0; seen = 1'b0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if8.cfg_valid = hold;
                if8.cfg_data  = next_data;
            end
            if (if8.sense_valid) begin
                seen = 1'b1;
            end else begin
                if (if8.cfg_ready !== 1'b0 || if8.busy !== 1'b1 || if8.ctrl_out[7:3] !== 5'd0) bad_rdy = 1'b1;
                if (if8.ctrl_out[0]) begin
                    if (!prev) begin
                        pulses++;
                        word = {word[6:0], if8.ctrl_out[1]};
                        if (lo != 2) bad_lo = 1'b1;
                        lo = 0;
                    end
                    hi++;
                end else begin
                    if (prev) begin
                        if (hi != 2) bad_hi = 1'b1;
                        hi = 0;
                    end
                    lo++;
                end
                if (if8.ctrl_out[2]) loads++;
                prev = if8.ctrl_out[0];
            end
        end
        check({tag, " sense_valid_seen"}, 32'(seen), 1);
        check({tag, " latency"}, 32'(n), 35);
        check({tag, " sdo_bits"}, 32'(word), 32'(exp_word));
        check({tag, " sclk_pulses"}, 32'(pulses), 8);
        check({tag, " load_cycles"}, 32'(loads), 2);
        check({tag, " sclk_high_len_bad"}, 32'(bad_hi), 0);
        check({tag, " sclk_low_len_bad"}, 32'(bad_lo), 0);
        check({tag, " ready_busy_bad"}, 32'(bad_rdy), 0);
        check({tag, " sense_data"}, 32'(if8.sense_data), 32'(exp_sense));
    endtask

    task automatic post(input logic [7:0] exp_sense, input string tag);
        @(negedge clk);
        check({tag, " single_pulse"}, 32'(if8.sense_valid), 0);
        check({tag, " idle_ready"}, 32'(if8.cfg_ready), 1);
        check({tag, " idle_busy"}, 32'(if8.busy), 0);
        check({tag, " sense_hold"}, 32'(if8.sense_data), 32'(exp_sense));
    endtask

    initial begin
        logic [3:0] exp1_out [4];
        logic       exp1_sv  [4];
        logic       bad;
        n_pass = 0;
        n_total = 0;
        mode = 0;
        vecs[0] = '{8'hA5, 0, 8'hA5, "vec_a5_loop"};
        vecs[1] = '{8'h3C, 0, 8'h3C, "vec_3c_loop"};
        vecs[2] = '{8'h5A, 1, 8'hA5, "vec_5a_inv"};
        vecs[3] = '{8'h00, 3, 8'hFF, "vec_00_one"};
        vecs[4] = '{8'hFF, 2, 8'h00, "vec_ff_zero"};
        vecs[5] = '{8'h81, 0, 8'h81, "vec_81_loop"};
        exp1_out = '{4'b0010, 4'b0011, 4'b0100, 4'b0000};
        exp1_sv  = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst8 = 1'b1; rst1 = 1'b1;
        if8.cfg_valid = 1'b0; if8.cfg_data = '0;
        if1.cfg_valid = 1'b0; if1.cfg_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst ctrl_out", 32'(if8.ctrl_out), 0);
            check("rst sense_valid", 32'(if8.sense_valid), 0);
            check("rst busy", 32'(if8.busy), 0);
            check("rst cfg_ready", 32'(if8.cfg_ready), 0);
        end
        check("rst ctrl_oe", 32'(if8.ctrl_oe), 32'h07);
        check("rst sense_data", 32'(if8.sense_data), 0);
        check("rst ctrl_oe cw1", 32'(if1.ctrl_oe), 32'h7);
        rst8 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("ready after release", 32'(if8.cfg_ready), 1);
        check("ready after release cw1", 32'(if1.cfg_ready), 1);

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            accept(vecs[i].data, vecs[i].name);
            watch(vecs[i].data, vecs[i].exp_sense, 1'b0, vecs[i].data, vecs[i].name);
            post(vecs[i].exp_sense, vecs[i].name);
        end

        // Back-to-back with cfg_valid held high
        mode = 0;
        accept(8'h01, "b2b_first");
        watch(8'h01, 8'h01, 1'b1, 8'hFF, "b2b_first");
        @(negedge clk);
        check("b2b gap ready", 32'(if8.cfg_ready), 1);
        check("b2b gap busy", 32'(if8.busy), 0);
        check("b2b gap sense_valid", 32'(if8.sense_valid), 0);
        @(posedge clk);
        watch(8'hFF, 8'hFF, 1'b0, 8'hFF, "b2b_second");
        post(8'hFF, "b2b_second");

        // Reset during the 4th SHIFT_HI (cycles 15-16 after accept)
        accept(8'hC3, "midrst");
        @(negedge clk);
        if8.cfg_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("midrst sclk_high_before", 32'(if8.ctrl_out[0]), 1);
        check("midrst busy_before", 32'(if8.busy), 1);
        rst8 = 1'b1;
        @(negedge clk);
        check("midrst ctrl_out", 32'(if8.ctrl_out), 0);
        check("midrst busy", 32'(if8.busy), 0);
        check("midrst sense_valid", 32'(if8.sense_valid), 0);
        check("midrst sense_data", 32'(if8.sense_data), 0);
        rst8 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if8.sense_valid !== 1'b0 || if8.ctrl_out !== 8'h00 || if8.busy !== 1'b0) bad = 1'b1;
        end
        check("midrst quiet_after", 32'(bad), 0);
        accept(8'h5A, "after_rst");
        watch(8'h5A, 8'h5A, 1'b0, 8'h5A, "after_rst");
        post(8'h5A, "after_rst");

        // Minimal configuration: CW=1, DIV=1, sdi tied 1
        @(negedge clk);
        check("cw1 ready", 32'(if1.cfg_ready), 1);
        if1.cfg_valid = 1'b1;
        if1.cfg_data  = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) if1.cfg_valid = 1'b0;
            check($sformatf("cw1 ctrl_out c%0d", c + 1), 32'(if1.ctrl_out), 32'(exp1_out[c]));
            check($sformatf("cw1 sense_valid c%0d", c + 1), 32'(if1.sense_valid), 32'(exp1_sv[c]));
        end
        check("cw1 sense_data", 32'(if1.sense_data), 1);
        @(negedge clk);
        check("cw1 single_pulse", 32'(if1.sense_valid), 0);
        check("cw1 idle_ready", 32'(if1.cfg_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
